riscv_mem_arbiter: RTL and testbench

- Shares the single-port synchronous RAM between three requesters: instruction fetch, load/store unit (LSU) and a debug/program loader port.
- Sits between the CPU core and the `ramm` instance.
- Replaces the core's ad-hoc "address = load||store ? storeloadaddr : pc" mux with an explicit req/gnt/rvalid handshake.
- Uses fixed priority with an anti-starvation override for fetch.

---
 rtl/riscv_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares one single-port synchronous RAM between instruction fetch, the
//   load/store unit and a debug/program-loader port using a req/gnt/rvalid
//   handshake. Fixed priority dbg > lsu > fetch, except that fetch is promoted
//   above lsu after STARVE_LIMIT consecutive lost arbitration cycles.
//   Writes complete in the grant cycle; reads return one cycle after grant.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   fetch_req/addr -> fetch_gnt/rvalid            read-only fetch port
//   lsu_req/we/addr/wdata -> lsu_gnt/rvalid       load/store port
//   dbg_req/we/addr/wdata -> dbg_gnt/rvalid       debug/loader port
//   rdata                            shared read data (0 unless an rvalid is high)
//   mem_addr/mem_data/mem_wren       RAM request side
//   mem_q                            RAM read data, one cycle after address
module riscv_mem_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic {ST_IDLE, ST_RDWAIT} state_t;
    typedef enum logic [1:0] {OWN_FETCH, OWN_LSU, OWN_DBG} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        r_state;
    owner_t        r_owner;
    logic [3:0]    r_starve_cnt;
    logic [AW-1:0] r_last_addr;

    logic          w_fetch_promote;
    logic          w_gnt_fetch, w_gnt_lsu, w_gnt_dbg;
    logic          w_grant, w_we;
    owner_t        w_owner;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_rd_phase;

    assign w_fetch_promote = fetch_req && (r_starve_cnt == LIMIT);

    // Winner selection; only active in IDLE and outside reset.
    always_comb begin
        w_gnt_fetch = 1'b0;
        w_gnt_lsu   = 1'b0;
        w_gnt_dbg   = 1'b0;
        w_we        = 1'b0;
        w_owner     = OWN_FETCH;
        w_addr      = r_last_addr;
        w_wdata     = '0;
        if (!reset && r_state == ST_IDLE) begin
            if (dbg_req) begin
                w_gnt_dbg = 1'b1;
                w_we      = dbg_we;
                w_owner   = OWN_DBG;
                w_addr    = dbg_addr;
                w_wdata   = dbg_wdata;
            end else if (lsu_req && !w_fetch_promote) begin
                w_gnt_lsu = 1'b1;
                w_we      = lsu_we;
                w_owner   = OWN_LSU;
                w_addr    = lsu_addr;
                w_wdata   = lsu_wdata;
            end else if (fetch_req) begin
                w_gnt_fetch = 1'b1;
                w_owner     = OWN_FETCH;
                w_addr      = fetch_addr;
            end
        end
    end

    assign w_grant    = w_gnt_fetch || w_gnt_lsu || w_gnt_dbg;
    assign w_rd_phase = !reset && (r_state == ST_RDWAIT);

    assign fetch_gnt    = w_gnt_fetch;
    assign lsu_gnt      = w_gnt_lsu;
    assign dbg_gnt      = w_gnt_dbg;
    assign mem_addr     = reset ? '0 : w_addr;
    assign mem_data     = w_wdata;
    assign mem_wren     = w_grant && w_we;
    assign fetch_rvalid = w_rd_phase && (r_owner == OWN_FETCH);
    assign lsu_rvalid   = w_rd_phase && (r_owner == OWN_LSU);
    assign dbg_rvalid   = w_rd_phase && (r_owner == OWN_DBG);
    assign rdata        = w_rd_phase ? mem_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_FETCH;
            r_starve_cnt <= '0;
            r_last_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        // RAM address holds the last granted address while idle.
                        r_last_addr <= w_addr;
                        if (!w_we) begin
                            r_owner <= w_owner;
                            r_state <= ST_RDWAIT;
                        end
                    end
                    if (fetch_req && !w_gnt_fetch) begin
                        if (r_starve_cnt < LIMIT)
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_RDWAIT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req, lsu_req, lsu_we, dbg_req, dbg_we;
    logic [AW-1:0] fetch_addr, lsu_addr, dbg_addr;
    logic [DW-1:0] lsu_wdata, dbg_wdata;
    logic          fetch_gnt, fetch_rvalid, lsu_gnt, lsu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] rdata, mem_data, mem_q;
    logic [AW-1:0] mem_addr;
    logic          mem_wren;

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // Environment RAM standing in for the ramm instance.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected RAM image, pending read record and count of consecutive
    // arbitration rounds fetch has lost.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_pend = 1'b0;
    int            m_pown;              // 1 fetch, 2 lsu, 3 dbg
    logic [AW-1:0] m_paddr;
    int            m_lost = 0;
    logic [AW-1:0] m_last = '0;

    always @(negedge clk) begin
        int            win;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_rdata;
        logic [2:0]    e_rv;
        if (run) begin
            win = 0; e_we = 1'b0; e_addr = m_last; e_data = '0; e_rdata = '0; e_rv = 3'b000;
            if (reset) begin
                e_addr = '0;
            end else if (m_pend) begin
                e_rv    = 3'b001 << (m_pown - 1);
                e_rdata = shadow[m_paddr];
            end else begin
                if (dbg_req) win = 3;
                else if (fetch_req && (m_lost >= LIMIT || !lsu_req)) win = 1;
                else if (lsu_req) win = 2;
                case (win)
                    1: begin e_addr = fetch_addr; end
                    2: begin e_addr = lsu_addr; e_we = lsu_we; e_data = lsu_wdata; end
                    3: begin e_addr = dbg_addr; e_we = dbg_we; e_data = dbg_wdata; end
                    default: ;
                endcase
            end
            chk("fetch_gnt", fetch_gnt, win == 1);
            chk("lsu_gnt", lsu_gnt, win == 2);
            chk("dbg_gnt", dbg_gnt, win == 3);
            chk("rvalid", {dbg_rvalid, lsu_rvalid, fetch_rvalid}, e_rv);
            chk("rdata", rdata, e_rdata);
            chk("mem_wren", mem_wren, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data", mem_data, e_data);
            chk("rvalid_onehot", $countones({dbg_rvalid, lsu_rvalid, fetch_rvalid}) <= 1, 1);
            // model state update
            if (reset) begin
                m_pend = 1'b0; m_lost = 0; m_last = '0;
            end else if (m_pend) begin
                m_pend = 1'b0;
            end else begin
                if (win != 0) begin
                    m_last = e_addr;
                    if (e_we) shadow[e_addr] = e_data;
                    else begin m_pend = 1'b1; m_pown = win; m_paddr = e_addr; end
                end
                if (fetch_req && win != 1) m_lost = (m_lost < LIMIT) ? m_lost + 1 : m_lost;
                else m_lost = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // lsu writes every cycle while fetch waits; fetch must win on the
    // (LIMIT+1)th round, then lsu resumes after the fetch read returns.
    task automatic starve_run(input logic [AW-1:0] base);
        fetch_req = 1; fetch_addr = 12'h010;
        lsu_req = 1; lsu_we = 1; lsu_addr = base; lsu_wdata = 32'hA000_0000 | 32'(base);
        for (int i = 0; i <= LIMIT; i++) begin
            sample;
            if (i < LIMIT) begin
                chk("starve_lsu_gnt", lsu_gnt, 1);
                chk("starve_fetch_wait", fetch_gnt, 0);
            end else begin
                chk("starve_fetch_gnt", fetch_gnt, 1);
                chk("starve_lsu_wait", lsu_gnt, 0);
            end
            step;
            if (i < LIMIT) begin lsu_addr = lsu_addr + 1; lsu_wdata = lsu_wdata + 1; end
            else fetch_req = 0;
        end
        sample;
        chk("starve_fetch_rvalid", fetch_rvalid, 1);
        chk("starve_fetch_rdata", rdata, 32'h0050_0093);
        step;
        sample;
        chk("starve_lsu_resume", lsu_gnt, 1);
        step;
        lsu_req = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; shadow[i] = '0; end
        ram[12'h010] = 32'h0050_0093; shadow[12'h010] = 32'h0050_0093;
        ram[12'h030] = 32'h1234_5678; shadow[12'h030] = 32'h1234_5678;

        reset = 1; fetch_req = 1; fetch_addr = 12'h010;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        step; run = 1'b1;
        sample;
        chk("reset_fetch_gnt", fetch_gnt, 0);
        chk("reset_mem_addr", mem_addr, 0);
        step;

        // single fetch read
        reset = 0;
        sample; chk("f_gnt", fetch_gnt, 1); chk("f_addr", mem_addr, 12'h010);
        step; fetch_req = 0;
        sample; chk("f_rvalid", fetch_rvalid, 1); chk("f_rdata", rdata, 32'h0050_0093);
        step;
        sample; chk("f_idle_rdata", rdata, 0); chk("f_idle_addr", mem_addr, 12'h010);

        // lsu write then read-back
        lsu_req = 1; lsu_we = 1; lsu_addr = 12'h020; lsu_wdata = 32'hDEAD_BEEF;
        sample; chk("w_wren", mem_wren, 1); chk("w_gnt", lsu_gnt, 1);
        step; lsu_we = 0;
        sample; chk("r_gnt", lsu_gnt, 1); chk("r_wren", mem_wren, 0);
        step; lsu_req = 0;
        sample; chk("r_rvalid", lsu_rvalid, 1); chk("r_rdata", rdata, 32'hDEAD_BEEF);
        step;

        // three simultaneous reads: dbg, lsu, fetch at 2-cycle spacing
        fetch_req = 1; fetch_addr = 12'h010;
        lsu_req = 1; lsu_we = 0; lsu_addr = 12'h020;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h030;
        sample; chk("tri_dbg_gnt", dbg_gnt, 1);
        step; dbg_req = 0;
        sample; chk("tri_dbg_rdata", rdata, 32'h1234_5678);
        step;
        sample; chk("tri_lsu_gnt", lsu_gnt, 1);
        step; lsu_req = 0;
        sample; chk("tri_lsu_rvalid", lsu_rvalid, 1);
        step;
        sample; chk("tri_fetch_gnt", fetch_gnt, 1);
        step; fetch_req = 0;
        sample; chk("tri_fetch_rvalid", fetch_rvalid, 1);
        step;

        // starvation override
        starve_run(12'h040);
        lsu_req = 1; lsu_we = 0; lsu_addr = 12'h042;
        sample; chk("rb_gnt", lsu_gnt, 1);
        step; lsu_req = 0;
        sample; chk("rb_rdata", rdata, 32'hA000_0042);
        step;

        // reset during RDWAIT drops the read
        lsu_req = 1; lsu_we = 0; lsu_addr = 12'h020;
        sample; chk("rst_rd_gnt", lsu_gnt, 1);
        step; lsu_req = 0; reset = 1;
        sample; chk("rst_rvalid", lsu_rvalid, 0); chk("rst_rdata", rdata, 0);
        step; reset = 0; fetch_req = 1; fetch_addr = 12'h010;
        sample; chk("rst_fetch_gnt", fetch_gnt, 1);
        step; fetch_req = 0;
        sample; chk("rst_fetch_rvalid", fetch_rvalid, 1);
        step;

        // fetch withdrawn while dbg writes hold the port
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h060; dbg_wdata = 32'h0BAD_F00D;
        fetch_req = 1; fetch_addr = 12'h050;
        for (int i = 0; i < 3; i++) begin
            sample; chk("wd_no_fetch", fetch_gnt, 0); chk("wd_dbg_addr", mem_addr, 12'h060);
            step;
            if (i == 1) fetch_req = 0;
        end
        dbg_req = 0;
        sample; chk("wd_idle_wren", mem_wren, 0); chk("wd_idle_addr", mem_addr, 12'h060);
        step;
        // cleared counter: fetch again needs a full LIMIT losses
        starve_run(12'h070);
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
